// File: rtl/decode_stage.sv
// RV32IM decoder feeding the ID/EX pipeline register, with load-use hazard detection.
// Define RV32M_EN to decode the M-extension (funct7 0000001) OP instructions.
module decode_stage (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        IF_VALID,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] PC,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        LOAD_USE_STALL,
    output logic        EX_VALID,
    output logic [31:0] EX_PC,
    output logic [4:0]  ALU_OPCODE,
    output logic [31:0] IMM,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    output logic [4:0]  RD_ADDR,
    output logic [1:0]  ALU_SRC1_SEL,
    output logic        ALU_SRC2_SEL,
    output logic [1:0]  WB_SEL,
    output logic        REG_WRITE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic        JUMP,
    output logic        ILLEGAL,
    output logic [2:0]  FUNCT3
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

`ifdef RV32M_EN
    localparam logic M_EN = 1'b1;
`else
    localparam logic M_EN = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  alu_op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  src1;
        logic        src2;
        logic [1:0]  wb;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [2:0]  funct3;
    } idex_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;

    assign opcode = INSTRUCTION[6:0];
    assign rd     = INSTRUCTION[11:7];
    assign f3     = INSTRUCTION[14:12];
    assign rs1    = INSTRUCTION[19:15];
    assign rs2    = INSTRUCTION[24:20];
    assign f7     = INSTRUCTION[31:25];

    assign i_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
    assign s_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
    assign b_imm = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                    INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
    assign u_imm = {INSTRUCTION[31:12], 12'b0};
    assign j_imm = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};

    idex_t dec;
    idex_t ex_q;
    logic  bad;

    always_comb begin
        dec       = '0;
        bad       = 1'b0;
        dec.valid = 1'b1;
        dec.pc    = PC;
        case (opcode)
            OPC_OP: begin
                bad = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) ||
                        (M_EN && f7 == 7'b0000001));
                dec.alu_op    = {f7[0], f7[5], f3};
                dec.rs1       = rs1;
                dec.rs2       = rs2;
                dec.rd        = rd;
                dec.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op    = {2'b00, f3};
                dec.imm       = i_imm;
                dec.rs1       = rs1;
                dec.rd        = rd;
                dec.src2      = 1'b1;
                dec.reg_write = 1'b1;
                if (f3 == 3'd1) begin
                    bad     = (f7 != 7'b0000000);
                    dec.imm = {27'b0, INSTRUCTION[24:20]};
                end else if (f3 == 3'd5) begin
                    bad        = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                    dec.alu_op = f7[5] ? 5'd13 : 5'd5;
                    dec.imm    = {27'b0, INSTRUCTION[24:20]};
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.imm       = u_imm;
                dec.rd        = rd;
                dec.src1      = (opcode == OPC_LUI) ? SRC1_ZERO : SRC1_PC;
                dec.src2      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.imm       = j_imm;
                dec.rd        = rd;
                dec.src1      = SRC1_PC;
                dec.src2      = 1'b1;
                dec.wb        = WB_PC4;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec.imm       = i_imm;
                dec.rs1       = rs1;
                dec.rd        = rd;
                dec.src1      = SRC1_RS1;
                dec.src2      = 1'b1;
                dec.wb        = WB_PC4;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm    = b_imm;
                dec.rs1    = rs1;
                dec.rs2    = rs2;
                dec.src1   = SRC1_PC;
                dec.src2   = 1'b1;
                dec.branch = 1'b1;
                dec.funct3 = f3;
            end
            OPC_LOAD: begin
                dec.imm       = i_imm;
                dec.rs1       = rs1;
                dec.rd        = rd;
                dec.src2      = 1'b1;
                dec.wb        = WB_MEM;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.funct3    = f3;
            end
            OPC_STORE: begin
                dec.imm       = s_imm;
                dec.rs1       = rs1;
                dec.rs2       = rs2;
                dec.src2      = 1'b1;
                dec.mem_write = 1'b1;
                dec.funct3    = f3;
            end
            OPC_FENCE: ;
            default: bad = 1'b1;
        endcase
        // Illegal encodings still flow down the pipe so EX can raise the trap.
        if (bad) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.pc      = PC;
            dec.illegal = 1'b1;
        end
    end

    logic uses_rs1;
    logic uses_rs2;

    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));

    assign LOAD_USE_STALL = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && IF_VALID &&
                            !STALL &&
                            ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ex_q <= '0;
        end else if (FLUSH) begin
            ex_q <= '0;
        end else if (STALL) begin
            ex_q <= ex_q;
        end else if (LOAD_USE_STALL || !IF_VALID) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec;
        end
    end

    assign EX_VALID     = ex_q.valid;
    assign EX_PC        = ex_q.pc;
    assign ALU_OPCODE   = ex_q.alu_op;
    assign IMM          = ex_q.imm;
    assign RS1_ADDR     = ex_q.rs1;
    assign RS2_ADDR     = ex_q.rs2;
    assign RD_ADDR      = ex_q.rd;
    assign ALU_SRC1_SEL = ex_q.src1;
    assign ALU_SRC2_SEL = ex_q.src2;
    assign WB_SEL       = ex_q.wb;
    assign REG_WRITE_EN = ex_q.reg_write;
    assign MEM_READ     = ex_q.mem_read;
    assign MEM_WRITE    = ex_q.mem_write;
    assign BRANCH       = ex_q.branch;
    assign JUMP         = ex_q.jump;
    assign ILLEGAL      = ex_q.illegal;
    assign FUNCT3       = ex_q.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage; each task drives one scenario and checks inline.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        IF_VALID;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        STALL;
    logic        FLUSH;
    logic        LOAD_USE_STALL;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic [4:0]  ALU_OPCODE;
    logic [31:0] IMM;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic [4:0]  RD_ADDR;
    logic [1:0]  ALU_SRC1_SEL;
    logic        ALU_SRC2_SEL;
    logic [1:0]  WB_SEL;
    logic        REG_WRITE_EN;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        BRANCH;
    logic        JUMP;
    logic        ILLEGAL;
    logic [2:0]  FUNCT3;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    decode_stage dut (
        .CLK(CLK), .RESETN(RESETN), .IF_VALID(IF_VALID), .INSTRUCTION(INSTRUCTION),
        .PC(PC), .STALL(STALL), .FLUSH(FLUSH), .LOAD_USE_STALL(LOAD_USE_STALL),
        .EX_VALID(EX_VALID), .EX_PC(EX_PC), .ALU_OPCODE(ALU_OPCODE), .IMM(IMM),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
        .ALU_SRC1_SEL(ALU_SRC1_SEL), .ALU_SRC2_SEL(ALU_SRC2_SEL), .WB_SEL(WB_SEL),
        .REG_WRITE_EN(REG_WRITE_EN), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .BRANCH(BRANCH), .JUMP(JUMP), .ILLEGAL(ILLEGAL), .FUNCT3(FUNCT3)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        IF_VALID    = 1'b1;
        INSTRUCTION = inst;
        PC          = pc;
    endtask

    task automatic test_reset();
        RESETN = 1'b0; IF_VALID = 1'b0; INSTRUCTION = '0; PC = '0; STALL = 1'b0; FLUSH = 1'b0;
        #2;
        checks++;
        if ({EX_VALID, EX_PC, ALU_OPCODE, IMM, RD_ADDR, REG_WRITE_EN, MEM_READ, ILLEGAL} !== '0) begin
            errors++; $display("FAIL reset_outputs valid=%b pc=%h op=%0d imm=%h rd=%0d got nonzero, want all 0",
                               EX_VALID, EX_PC, ALU_OPCODE, IMM, RD_ADDR);
        end
        step();
        RESETN = 1'b1;
        step();
    endtask

    task automatic test_add();
        present(32'h002081B3, 32'h0000_0100);
        step();
        checks++;
        if ({EX_VALID, ALU_OPCODE, RS1_ADDR, RS2_ADDR, RD_ADDR, REG_WRITE_EN, ALU_SRC2_SEL, ILLEGAL}
            !== {1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_fields valid=%b op=%0d rs1=%0d rs2=%0d rd=%0d we=%b src2=%b ill=%b want 1 0 1 2 3 1 0 0",
                               EX_VALID, ALU_OPCODE, RS1_ADDR, RS2_ADDR, RD_ADDR, REG_WRITE_EN, ALU_SRC2_SEL, ILLEGAL);
        end
        checks++;
        if (EX_PC !== 32'h0000_0100) begin
            errors++; $display("FAIL add_pc got %h want 00000100", EX_PC);
        end
    endtask

    task automatic test_srai_beq();
        present(32'h40335293, 32'h0000_0104);
        step();
        checks++;
        if ({ALU_OPCODE, IMM, RS1_ADDR, RD_ADDR, ALU_SRC2_SEL, REG_WRITE_EN}
            !== {5'd13, 32'h3, 5'd6, 5'd5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL srai_fields op=%0d imm=%h rs1=%0d rd=%0d src2=%b we=%b want 13 00000003 6 5 1 1",
                               ALU_OPCODE, IMM, RS1_ADDR, RD_ADDR, ALU_SRC2_SEL, REG_WRITE_EN);
        end
        present(32'hFE208EE3, 32'h0000_0108);
        step();
        checks++;
        if (IMM !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL beq_imm got %h want fffffffc", IMM);
        end
        checks++;
        if ({BRANCH, ALU_SRC1_SEL, ALU_SRC2_SEL, REG_WRITE_EN, ALU_OPCODE, RS1_ADDR, RS2_ADDR, JUMP}
            !== {1'b1, 2'd1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0}) begin
            errors++; $display("FAIL beq_ctrl br=%b src1=%0d src2=%b we=%b op=%0d rs1=%0d rs2=%0d j=%b want 1 1 1 0 0 1 2 0",
                               BRANCH, ALU_SRC1_SEL, ALU_SRC2_SEL, REG_WRITE_EN, ALU_OPCODE, RS1_ADDR, RS2_ADDR, JUMP);
        end
    endtask

    task automatic test_load_use();
        present(32'h0000A203, 32'h0000_0200);
        step();
        checks++;
        if ({MEM_READ, WB_SEL, RD_ADDR, RS1_ADDR, FUNCT3, ALU_SRC2_SEL, REG_WRITE_EN}
            !== {1'b1, 2'd1, 5'd4, 5'd1, 3'd2, 1'b1, 1'b1}) begin
            errors++; $display("FAIL lw_ctrl mr=%b wb=%0d rd=%0d rs1=%0d f3=%0d src2=%b we=%b want 1 1 4 1 2 1 1",
                               MEM_READ, WB_SEL, RD_ADDR, RS1_ADDR, FUNCT3, ALU_SRC2_SEL, REG_WRITE_EN);
        end
        present(32'h004202B3, 32'h0000_0204);
        #1;
        checks++;
        if (LOAD_USE_STALL !== 1'b1) begin
            errors++; $display("FAIL load_use_raise got %b want 1", LOAD_USE_STALL);
        end
        step();
        checks++;
        if ({EX_VALID, MEM_READ, LOAD_USE_STALL} !== 3'b000) begin
            errors++; $display("FAIL load_use_bubble valid=%b mr=%b lus=%b want 0 0 0", EX_VALID, MEM_READ, LOAD_USE_STALL);
        end
        step();
        checks++;
        if ({EX_VALID, RD_ADDR, RS1_ADDR, RS2_ADDR} !== {1'b1, 5'd5, 5'd4, 5'd4}) begin
            errors++; $display("FAIL load_use_capture valid=%b rd=%0d rs1=%0d rs2=%0d want 1 5 4 4",
                               EX_VALID, RD_ADDR, RS1_ADDR, RS2_ADDR);
        end
        // A load into x0 never creates a hazard.
        present(32'h0000A003, 32'h0000_0208);
        step();
        present(32'h000002B3, 32'h0000_020C);
        #1;
        checks++;
        if (LOAD_USE_STALL !== 1'b0) begin
            errors++; $display("FAIL load_use_x0 got %b want 0", LOAD_USE_STALL);
        end
        step();
    endtask

    task automatic test_mul();
        present(32'h023100B3, 32'h0000_0300);
        step();
        checks++;
`ifdef RV32M_EN
        if ({EX_VALID, ALU_OPCODE, REG_WRITE_EN, ILLEGAL, RD_ADDR} !== {1'b1, 5'd16, 1'b1, 1'b0, 5'd1}) begin
            errors++; $display("FAIL mul_decode valid=%b op=%0d we=%b ill=%b rd=%0d want 1 16 1 0 1",
                               EX_VALID, ALU_OPCODE, REG_WRITE_EN, ILLEGAL, RD_ADDR);
        end
`else
        if ({EX_VALID, ALU_OPCODE, REG_WRITE_EN, ILLEGAL, RD_ADDR} !== {1'b1, 5'd0, 1'b0, 1'b1, 5'd0}) begin
            errors++; $display("FAIL mul_illegal valid=%b op=%0d we=%b ill=%b rd=%0d want 1 0 0 1 0",
                               EX_VALID, ALU_OPCODE, REG_WRITE_EN, ILLEGAL, RD_ADDR);
        end
`endif
    endtask

    task automatic test_illegal();
        // SLL with funct7 0100000 is not a legal OP encoding.
        present(32'h403110B3, 32'h0000_0400);
        step();
        checks++;
        if ({EX_VALID, ILLEGAL, ALU_OPCODE, REG_WRITE_EN} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
            errors++; $display("FAIL op_bad_funct7 valid=%b ill=%b op=%0d we=%b want 1 1 0 0",
                               EX_VALID, ILLEGAL, ALU_OPCODE, REG_WRITE_EN);
        end
        present(32'hFFFF_FFFF, 32'h0000_0404);
        step();
        checks++;
        if ({EX_VALID, ILLEGAL, MEM_READ, MEM_WRITE, JUMP, BRANCH} !== 6'b110000) begin
            errors++; $display("FAIL bad_opcode valid=%b ill=%b mr=%b mw=%b j=%b br=%b want 1 1 0 0 0 0",
                               EX_VALID, ILLEGAL, MEM_READ, MEM_WRITE, JUMP, BRANCH);
        end
        // JAL x1,+8
        present(32'h008000EF, 32'h0000_0408);
        step();
        checks++;
        if ({JUMP, WB_SEL, ALU_SRC1_SEL, IMM, RD_ADDR, REG_WRITE_EN} !== {1'b1, 2'd2, 2'd1, 32'd8, 5'd1, 1'b1}) begin
            errors++; $display("FAIL jal_ctrl j=%b wb=%0d src1=%0d imm=%h rd=%0d we=%b want 1 2 1 00000008 1 1",
                               JUMP, WB_SEL, ALU_SRC1_SEL, IMM, RD_ADDR, REG_WRITE_EN);
        end
    endtask

    task automatic test_stall_flush();
        present(32'h002081B3, 32'h0000_0500);
        step();
        present(32'h40335293, 32'h0000_0504);
        STALL = 1'b1;
        step();
        checks++;
        if ({EX_VALID, ALU_OPCODE, RD_ADDR, EX_PC} !== {1'b1, 5'd0, 5'd3, 32'h0000_0500}) begin
            errors++; $display("FAIL stall_hold valid=%b op=%0d rd=%0d pc=%h want 1 0 3 00000500",
                               EX_VALID, ALU_OPCODE, RD_ADDR, EX_PC);
        end
        FLUSH = 1'b1;
        step();
        checks++;
        if ({EX_VALID, REG_WRITE_EN, MEM_READ, MEM_WRITE, BRANCH, JUMP, ILLEGAL, EX_PC, RD_ADDR} !== '0) begin
            errors++; $display("FAIL stall_flush valid=%b we=%b pc=%h rd=%0d want all 0",
                               EX_VALID, REG_WRITE_EN, EX_PC, RD_ADDR);
        end
        STALL = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic test_async_reset();
        present(32'h002081B3, 32'h0000_0600);
        step();
        #2;
        RESETN = 1'b0;
        #1;
        checks++;
        if ({EX_VALID, REG_WRITE_EN, RD_ADDR, RS1_ADDR, EX_PC} !== '0) begin
            errors++; $display("FAIL async_reset valid=%b we=%b rd=%0d rs1=%0d pc=%h want all 0",
                               EX_VALID, REG_WRITE_EN, RD_ADDR, RS1_ADDR, EX_PC);
        end
        RESETN = 1'b1;
        IF_VALID = 1'b0;
        step();
        checks++;
        if ({EX_VALID, REG_WRITE_EN} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset valid=%b we=%b want 0 0", EX_VALID, REG_WRITE_EN);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_srai_beq();
        test_load_use();
        test_mul();
        test_illegal();
        test_stall_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
